// File: rtl/miner_reg_bank.sv
// miner_reg_bank: byte-addressed host register bank for the mining core.
//   0x00              STATUS  RO  {found_flag, found_lost, job_pending, 2'b0, state_in}
//   0x01              CTRL    WO  bit0 COMMIT, bit1 FOUND_CLR; reads 0
//   0x02..0x05        FOUND   RO  found_nonce, MSB first
//   NONCE_BASE+4c+b   NONCE   RO  channel c live nonce, MSB first
//   CFG_BASE+k        CFG     RW  shadow job config byte k
// Any 32-bit word is read tear-free: reading its MSB latches the whole word into a shared
// snapshot, and the three lower bytes are then served from that snapshot.
// The host edits a shadow config bank; COMMIT hands it to the active bank (seen by the hash
// cores) in a single edge at a job boundary via job_valid/job_ready.
// Optional build macro: MINER_REG_RD_PIPE_EN registers rd_data (latency 1, loaded on rd_en).
module miner_reg_bank #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 8,
  parameter int MID_BYTES = 32,
  parameter int HDR_BYTES = 12,
  parameter int TGT_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    rd_en,
  output logic [7:0]              rd_data,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic [2:0]              state_in,
  input  logic [32*NUM_CH-1:0]    nonce_live,
  input  logic                    found_valid,
  input  logic [7:0]              found_ch,
  input  logic [31:0]             found_nonce,
  output logic                    job_valid,
  input  logic                    job_ready,
  output logic [8*MID_BYTES-1:0]  midstate,
  output logic [8*HDR_BYTES-1:0]  header_left,
  output logic [8*TGT_BYTES-1:0]  target
);

  localparam int CFG_N       = MID_BYTES + HDR_BYTES + TGT_BYTES;
  localparam int ADDR_STATUS = 0;
  localparam int ADDR_CTRL   = 1;
  localparam int FOUND_BASE  = 2;
  localparam int NONCE_BASE  = 6;
  localparam int CFG_BASE    = NONCE_BASE + 4 * NUM_CH;

  logic [8*CFG_N-1:0] r_shadow;
  logic [8*CFG_N-1:0] r_active;
  logic [31:0]        r_snap;
  logic [31:0]        r_found_nonce;
  logic [7:0]         r_found_ch;
  logic               r_found_flag;
  logic               r_found_lost;
  logic               r_job_pending;

  logic               w_ctrl_wr;
  logic               w_commit;
  logic               w_found_clr;
  logic               w_xfer;
  logic [7:0]         w_status;
  logic [7:0]         w_rd_byte;
  logic               w_snap_load;
  logic [31:0]        w_snap_val;
  logic               w_unused_found_ch;

  assign w_ctrl_wr   = wr_en && (addr == ADDR_W'(ADDR_CTRL));
  assign w_commit    = w_ctrl_wr && wr_data[0];
  assign w_found_clr = w_ctrl_wr && wr_data[1];
  assign w_xfer      = r_job_pending && job_ready;
  assign w_status    = {r_found_flag, r_found_lost, r_job_pending, 2'b00, state_in};

  // The captured channel index has no readback register; it is held for future use only.
  assign w_unused_found_ch = ^r_found_ch;

  assign job_valid   = r_job_pending;
  assign midstate    = r_active[8*MID_BYTES-1:0];
  assign header_left = r_active[8*(MID_BYTES+HDR_BYTES)-1:8*MID_BYTES];
  assign target      = r_active[8*CFG_N-1:8*(MID_BYTES+HDR_BYTES)];

  // Host writes into the shadow config bank.
  always_ff @(posedge clk) begin
    // NOTE: the config banks are flop arrays that must read as zero after reset, so they are
    // reset explicitly rather than left to power-up values.
    if (!reset) begin
      r_shadow <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < CFG_N; k++) begin
        if (addr == ADDR_W'(CFG_BASE + k)) r_shadow[8*k +: 8] <= wr_data;
      end
    end
  end

  // Whole-bank transfer to the cores on the handshake edge; a same-cycle shadow write is not seen.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment samples r_shadow as it was before this edge's host write.
    if (!reset)      r_active <= '0;
    else if (w_xfer) r_active <= r_shadow;
  end

  // Job pending: set by COMMIT, cleared by the transfer; a fresh COMMIT re-arms it.
  always_ff @(posedge clk) begin
    if (!reset)        r_job_pending <= 1'b0;
    else if (w_commit) r_job_pending <= 1'b1;
    else if (w_xfer)   r_job_pending <= 1'b0;
  end

  // Found capture: first hit wins; later hits only flag loss; capture beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_found_flag  <= 1'b0;
      r_found_lost  <= 1'b0;
      r_found_ch    <= '0;
      r_found_nonce <= '0;
    end else if (found_valid) begin
      if (!r_found_flag || w_found_clr) begin
        r_found_flag  <= 1'b1;
        r_found_lost  <= 1'b0;
        r_found_ch    <= found_ch;
        r_found_nonce <= found_nonce;
      end else begin
        r_found_lost  <= 1'b1;
      end
    end else if (w_found_clr) begin
      r_found_flag <= 1'b0;
      r_found_lost <= 1'b0;
    end
  end

  // Read decode: MSB bytes come live, lower bytes from the snapshot taken at the MSB read.
  always_comb begin
    // NOTE: every output gets a default first so no path through the decode infers a latch.
    w_rd_byte   = '0;
    w_snap_load = 1'b0;
    w_snap_val  = '0;
    if (addr == ADDR_W'(ADDR_STATUS)) w_rd_byte = w_status;
    for (int b = 0; b < 4; b++) begin
      if (addr == ADDR_W'(FOUND_BASE + b)) begin
        if (b == 0) begin
          w_rd_byte   = r_found_nonce[31:24];
          w_snap_load = 1'b1;
          w_snap_val  = r_found_nonce;
        end else begin
          w_rd_byte   = r_snap[31-8*b -: 8];
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (addr == ADDR_W'(NONCE_BASE + 4*c + b)) begin
          if (b == 0) begin
            w_rd_byte   = nonce_live[32*c+31 -: 8];
            w_snap_load = 1'b1;
            w_snap_val  = nonce_live[32*c +: 32];
          end else begin
            w_rd_byte   = r_snap[31-8*b -: 8];
          end
        end
      end
    end
    for (int k = 0; k < CFG_N; k++) begin
      if (addr == ADDR_W'(CFG_BASE + k)) w_rd_byte = r_shadow[8*k +: 8];
    end
  end

  // Shared snapshot: latch the full word whenever its MSB byte is read.
  always_ff @(posedge clk) begin
    if (!reset)                    r_snap <= '0;
    else if (rd_en && w_snap_load) r_snap <= w_snap_val;
  end

`ifdef MINER_REG_RD_PIPE_EN
  logic [7:0] r_rd_data;

  // Registered read port: loads on rd_en, holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset)     r_rd_data <= '0;
    else if (rd_en) r_rd_data <= w_rd_byte;
  end

  assign rd_data = r_rd_data;
`else
  assign rd_data = w_rd_byte;
`endif

endmodule

// File: tb/tb_miner_reg_bank.sv
// tb_miner_reg_bank: directed scoreboard bench for miner_reg_bank (default parameters).
// Stimulus pushes hand-computed expectations; a monitor pops and compares when the DUT
// presents a read byte (or when an output observation is requested).
module tb_miner_reg_bank;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 8;
  localparam int CFG    = 22;
  localparam int CFG_N  = 76;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [ADDR_W-1:0]   addr = '0;
  logic                rd_en = 1'b0;
  logic [7:0]          rd_data;
  logic                wr_en = 1'b0;
  logic [7:0]          wr_data = '0;
  logic [2:0]          state_in = 3'd5;
  logic [32*NUM_CH-1:0] nonce_live = '0;
  logic                found_valid = 1'b0;
  logic [7:0]          found_ch = '0;
  logic [31:0]         found_nonce = '0;
  logic                job_valid;
  logic                job_ready = 1'b0;
  logic [255:0]        midstate;
  logic [95:0]         header_left;
  logic [255:0]        target;

  miner_reg_bank dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data), .state_in(state_in), .nonce_live(nonce_live),
    .found_valid(found_valid), .found_ch(found_ch), .found_nonce(found_nonce),
    .job_valid(job_valid), .job_ready(job_ready), .midstate(midstate),
    .header_left(header_left), .target(target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         src;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  logic obs_s = 1'b0;
  logic rd_d = 1'b0;
  logic flush_req = 1'b0;
  logic flush_done = 1'b0;
  logic present;

  always @(posedge clk) rd_d <= rd_en;

`ifdef MINER_REG_RD_PIPE_EN
  assign present = rd_d || obs_s;
`else
  assign present = rd_en || obs_s;
`endif

  function automatic logic [7:0] pick(input int src);
    case (src)
      0:       pick = rd_data;
      1:       pick = {7'b0, job_valid};
      2:       pick = midstate[7:0];
      3:       pick = {7'b0, |{midstate, header_left, target}};
      4:       pick = target[7:0];
      5:       pick = header_left[7:0];
      6:       pick = midstate[15:8];
      7:       pick = target[255:248];
      default: pick = 8'hxx;
    endcase
  endfunction

  // Monitor: compares the oldest expectation whenever the DUT presents an output.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    if (flush_req) begin
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks <= checks + 1;
        errors <= errors + 1;
        $display("FAIL %s: never presented, expected %02h", e.name, e.exp);
      end else begin
        flush_done <= 1'b1;
      end
    end else if (present) begin
      checks <= checks + 1;
      if (sbq.size() == 0) begin
        errors <= errors + 1;
        $display("FAIL unexpected_output: rd_data=%02h with no expectation queued", rd_data);
      end else begin
        e   = sbq.pop_front();
        act = pick(e.src);
        if (act !== e.exp) begin
          errors <= errors + 1;
          $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int src, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.src  = src;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    addr    = ADDR_W'(a);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // One read strobe cycle followed by an idle cycle, so either read latency is presented.
  task automatic rd(input string name, input int a, input logic [7:0] exp);
    push(name, 0, exp);
    addr  = ADDR_W'(a);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic obs(input string name, input int src, input logic [7:0] exp);
    push(name, src, exp);
    obs_s = 1'b1;
    tick();
    obs_s = 1'b0;
  endtask

  task automatic pulse_found(input logic [7:0] ch, input logic [31:0] n);
    found_ch    = ch;
    found_nonce = n;
    found_valid = 1'b1;
    tick();
    found_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    obs("rst_job_valid", 1, 8'h00);
    obs("rst_outputs", 3, 8'h00);
    rd("rst_status", 0, 8'h05);

    // Load and commit immediately.
    job_ready = 1'b1;
    wr(CFG + 0, 8'h11);
    wr(CFG + 32, 8'h22);
    wr(CFG + 44, 8'h33);
    wr(1, 8'h01);
    tick();
    job_ready = 1'b0;
    obs("commit_mid0", 2, 8'h11);
    obs("commit_hdr0", 5, 8'h22);
    obs("commit_tgt0", 4, 8'h33);
    obs("commit_jv_low", 1, 8'h00);

    // One-cycle reset after config.
    wr(CFG + 1, 8'h44);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    obs("rst2_outputs", 3, 8'h00);
    obs("rst2_job_valid", 1, 8'h00);
    rd("rst2_status", 0, 8'h05);
    rd("rst2_shadow0", CFG + 0, 8'h00);
    rd("rst2_shadow1", CFG + 1, 8'h00);

    // Tear-free nonce snapshot.
    nonce_live = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00C0FFEE};
    rd("snap_ch2_b0", 14, 8'hDE);
    nonce_live[95:64] = 32'h01020304;
    rd("snap_ch2_b1", 15, 8'hAD);
    rd("snap_ch2_b2", 16, 8'hBE);
    rd("snap_ch2_b3", 17, 8'hEF);
    rd("live_ch2_b0", 14, 8'h01);
    rd("resnap_ch2_b1", 15, 8'h02);
    rd("ch0_b0", 6, 8'h00);
    rd("ch0_b3", 9, 8'hEE);
    rd("ch3_b0", 18, 8'h33);
    rd("ch3_b3", 21, 8'h33);

    // Commit held off by job_ready.
    wr(CFG + 0, 8'hAA);
    wr(1, 8'h01);
    obs("hold_mid0", 2, 8'h00);
    obs("hold_jv", 1, 8'h01);
    rd("hold_status", 0, 8'h25);
    wr(CFG + 1, 8'h5B);
    wr(1, 8'h01);
    obs("recommit_jv", 1, 8'h01);
    obs("recommit_mid0", 2, 8'h00);
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    obs("xfer_mid0", 2, 8'hAA);
    obs("xfer_mid1_late_write", 6, 8'h5B);
    obs("xfer_jv_low", 1, 8'h00);
    rd("xfer_status", 0, 8'h05);

    // Shadow write in the transfer cycle stays in shadow only.
    wr(1, 8'h01);
    addr      = ADDR_W'(CFG);
    wr_data   = 8'hCC;
    wr_en     = 1'b1;
    job_ready = 1'b1;
    tick();
    wr_en     = 1'b0;
    job_ready = 1'b0;
    obs("xcyc_mid0_old", 2, 8'hAA);
    rd("xcyc_shadow0_new", CFG + 0, 8'hCC);
    obs("xcyc_jv_low", 1, 8'h00);

    // Region boundaries of the config map.
    job_ready = 1'b1;
    wr(CFG + 32, 8'h3C);
    wr(CFG + CFG_N - 1, 8'h77);
    wr(1, 8'h01);
    tick();
    job_ready = 1'b0;
    obs("bnd_hdr0", 5, 8'h3C);
    obs("bnd_tgt_last", 7, 8'h77);
    obs("bnd_mid0", 2, 8'hCC);

    // Found capture and loss.
    pulse_found(8'd1, 32'h12345678);
    pulse_found(8'd1, 32'h00000009);
    rd("found_status", 0, 8'hC5);
    rd("found_b0", 2, 8'h12);
    rd("found_b1", 3, 8'h34);
    rd("found_b2", 4, 8'h56);
    rd("found_b3", 5, 8'h78);

    // FOUND_CLR together with a new hit: the capture wins.
    found_ch    = 8'd2;
    found_nonce = 32'h00000055;
    found_valid = 1'b1;
    addr        = ADDR_W'(1);
    wr_data     = 8'h02;
    wr_en       = 1'b1;
    tick();
    found_valid = 1'b0;
    wr_en       = 1'b0;
    rd("clrcap_status", 0, 8'h85);
    rd("clrcap_b0", 2, 8'h00);
    rd("clrcap_b1", 3, 8'h00);
    rd("clrcap_b2", 4, 8'h00);
    rd("clrcap_b3", 5, 8'h55);

    // Plain clear, then a hit on an out-of-range channel index.
    wr(1, 8'h02);
    rd("clr_status", 0, 8'h05);
    pulse_found(8'd9, 32'hAABBCCDD);
    rd("ch9_status", 0, 8'h85);
    rd("ch9_b0", 2, 8'hAA);
    rd("ch9_b3", 5, 8'hDD);

    // Unmapped and read-only addresses.
    wr(0, 8'hFF);
    rd("ro_status", 0, 8'h85);
    wr(CFG + CFG_N, 8'h99);
    rd("past_cfg", CFG + CFG_N, 8'h00);
    rd("ctrl_reads0", 1, 8'h00);
    rd("addr_ff", 255, 8'h00);
    rd("cfg0_again", CFG + 0, 8'hCC);

    flush_req = 1'b1;
    for (int i = 0; i < 200 && !flush_done; i++) tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
